// File: rtl/fu_broadcast_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fu_bcast_pkg
// Shared definitions for the functional-unit broadcast arbiter:
//   - default result/tag widths
//   - bcast_entry_t : {tag, data} view of one broadcast entry at default widths
//   - occ_width()   : width of an occupancy counter able to hold 0..depth
// -----------------------------------------------------------------------------
package fu_bcast_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TAG_WIDTH  = 7;

  typedef struct packed {
    logic [DEF_TAG_WIDTH-1:0]  tag;
    logic [DEF_DATA_WIDTH-1:0] data;
  } bcast_entry_t;

  // A counter that must reach 'depth' itself needs one bit above the index width.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fu_broadcast_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational one-hot arbiter over NUM_REQ request lines.
//   Default build      : round-robin, search starts at i_ptr and wraps.
//   BCAST_FIXED_PRIO_EN: fixed priority, lowest index wins; no pointer port.
// Ports:
//   i_req         request vector
//   i_ptr         round-robin start index (absent with BCAST_FIXED_PRIO_EN)
//   i_en          grant enable; no grant is issued while low
//   o_grant       one-hot grant (all zero when nothing granted)
//   o_grant_idx   encoded index of the granted request
//   o_grant_valid a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter
  import fu_bcast_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifndef BCAST_FIXED_PRIO_EN
  input  logic [PTR_W-1:0]   i_ptr,
`endif
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_grant_idx,
  output logic               o_grant_valid
);

`ifdef BCAST_FIXED_PRIO_EN

  // Scan from the top down so the lowest requesting index is the last writer.
  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_en && i_req[k]) begin
        o_grant       = '0;
        o_grant[k]    = 1'b1;
        o_grant_idx   = PTR_W'(k);
        o_grant_valid = 1'b1;
      end
    end
  end

`else

  int w_idx;

  // Walk NUM_REQ positions starting at i_ptr; the first requester found wins.
  // i_ptr is always < NUM_REQ, so one conditional subtract performs the wrap.
  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (i_en && !o_grant_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = PTR_W'(w_idx);
        o_grant_valid  = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/fu_broadcast_arbiter.sv
// -----------------------------------------------------------------------------
// fu_broadcast_arbiter
// Collects completed results from NUM_FU functional units, arbitrates them into
// a QUEUE_DEPTH-entry broadcast FIFO, and drains the FIFO onto the CDB.
// Optional macro: BCAST_FIXED_PRIO_EN (fixed lowest-index-wins priority instead
// of round-robin; the round-robin pointer is then not built).
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   fu_done      per-FU single-cycle completion pulse
//   fu_result    flattened results, FU i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fu_tag       flattened tags,    FU i at [i*TAG_WIDTH  +: TAG_WIDTH]
//   fu_queued    registered one-cycle pulse: FU's result entered the FIFO
//   cdb_valid    FIFO head valid
//   cdb_data     head result
//   cdb_tag      head tag
//   cdb_ready    consumer accepts head this cycle
//   queue_count  FIFO occupancy
//   overrun      sticky: done arrived while that FU's result was still pending
//
// Handshake: the CDB head transfers on a rising edge where cdb_valid and
// cdb_ready are both high. cdb_ready while empty is ignored, and a push into
// an empty FIFO becomes visible on the CDB only from the following cycle.
// -----------------------------------------------------------------------------
module fu_broadcast_arbiter
  import fu_bcast_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
  parameter int NUM_FU      = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_FU-1:0]              fu_done,
  input  logic [NUM_FU*DATA_WIDTH-1:0]   fu_result,
  input  logic [NUM_FU*TAG_WIDTH-1:0]    fu_tag,
  output logic [NUM_FU-1:0]              fu_queued,
  output logic                           cdb_valid,
  output logic [DATA_WIDTH-1:0]          cdb_data,
  output logic [TAG_WIDTH-1:0]           cdb_tag,
  input  logic                           cdb_ready,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           overrun
);

  localparam int PTR_W = $clog2(NUM_FU);
  localparam int AW    = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = occ_width(QUEUE_DEPTH);
  localparam int EW    = TAG_WIDTH + DATA_WIDTH;

  // Capture stage
  logic [NUM_FU-1:0]     r_pending;
  logic [DATA_WIDTH-1:0] r_cap_data [NUM_FU];
  logic [TAG_WIDTH-1:0]  r_cap_tag  [NUM_FU];

  // Broadcast FIFO, entry layout {tag, data}
  logic [EW-1:0]         r_fifo [QUEUE_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [NUM_FU-1:0]     r_queued;
  logic                  r_overrun;

  logic                  w_pop;
  logic                  w_grant_en;
  logic [NUM_FU-1:0]     w_grant;
  logic [PTR_W-1:0]      w_grant_idx;
  logic                  w_grant_valid;
  logic [EW-1:0]         w_push_entry;

  // A pop frees a slot in the same edge, so a full FIFO being drained still
  // accepts a push.
  assign w_pop        = (r_count != '0) && cdb_ready;
  assign w_grant_en   = (r_count != CNT_W'(QUEUE_DEPTH)) || w_pop;
  assign w_push_entry = {r_cap_tag[w_grant_idx], r_cap_data[w_grant_idx]};

`ifdef BCAST_FIXED_PRIO_EN

  rr_arbiter #(
    .NUM_REQ (NUM_FU),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_req         (r_pending),
    .i_en          (w_grant_en),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

`else

  logic [PTR_W-1:0] r_rr_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_FU),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_req         (r_pending),
    .i_ptr         (r_rr_ptr),
    .i_en          (w_grant_en),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  // Next search starts just past the unit that was served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant_valid) begin
      if (w_grant_idx == PTR_W'(NUM_FU - 1)) begin
        r_rr_ptr <= '0;
      end else begin
        r_rr_ptr <= w_grant_idx + PTR_W'(1);
      end
    end
  end

`endif

  // Capture registers and pending flags. A done coincident with the grant of
  // the same unit pushes the old value (read combinationally above) and
  // re-arms pending with the new one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        r_cap_data[i] <= '0;
        r_cap_tag[i]  <= '0;
      end
    end else begin
      r_pending <= (r_pending & ~w_grant) | fu_done;
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_done[i]) begin
          r_cap_data[i] <= fu_result[i*DATA_WIDTH +: DATA_WIDTH];
          r_cap_tag[i]  <= fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
        end
      end
    end
  end

  // Overrun: a unit completed again before its previous result left the
  // capture stage, so the previous result is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (|(fu_done & r_pending & ~w_grant)) begin
      r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_queued <= '0;
    end else begin
      r_queued <= w_grant;
    end
  end

  // FIFO storage is cleared on reset so the CDB never exposes stale data
  // from before the reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < QUEUE_DEPTH; e++) begin
        r_fifo[e] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_grant_valid) begin
        r_fifo[r_wr_ptr] <= w_push_entry;
        r_wr_ptr         <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_grant_valid, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign cdb_valid             = (r_count != '0);
  assign {cdb_tag, cdb_data}   = r_fifo[r_rd_ptr];
  assign fu_queued             = r_queued;
  assign queue_count           = r_count;
  assign overrun               = r_overrun;

endmodule

// File: tb/tb_fu_broadcast_arbiter.sv
module tb_fu_broadcast_arbiter;

  localparam int NF  = 4;
  localparam int DW  = 32;
  localparam int TW  = 7;
  localparam int QD  = 4;

  // ---------------------------------------------------------------- clock/reset
  logic              clk = 1'b0;
  logic              rst;
  logic [NF-1:0]     fu_done;
  logic [NF*DW-1:0]  fu_result;
  logic [NF*TW-1:0]  fu_tag;
  logic [NF-1:0]     fu_queued;
  logic              cdb_valid;
  logic [DW-1:0]     cdb_data;
  logic [TW-1:0]     cdb_tag;
  logic              cdb_ready;
  logic [2:0]        queue_count;
  logic              overrun;

  always #5 clk = ~clk;

  fu_broadcast_arbiter #(
    .DATA_WIDTH  (DW),
    .TAG_WIDTH   (TW),
    .NUM_FU      (NF),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fu_done     (fu_done),
    .fu_result   (fu_result),
    .fu_tag      (fu_tag),
    .fu_queued   (fu_queued),
    .cdb_valid   (cdb_valid),
    .cdb_data    (cdb_data),
    .cdb_tag     (cdb_tag),
    .cdb_ready   (cdb_ready),
    .queue_count (queue_count),
    .overrun     (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  // --------------------------------------------------------- reference model
  // Transaction-level view: per-FU pending slot, FIFO as a queue of {tag,data}.
  bit              m_pend [NF];
  logic [DW-1:0]   m_data [NF];
  logic [TW-1:0]   m_tag  [NF];
  logic [TW+DW-1:0] exp_q [$];
  int              m_rr;
  bit              m_ovr;
  logic [NF-1:0]   exp_queued;

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_pend[i] = 1'b0;
      m_data[i] = '0;
      m_tag[i]  = '0;
    end
    exp_q.delete();
    m_rr       = 0;
    m_ovr      = 1'b0;
    exp_queued = '0;
  endtask

  // Applies the rules for one clock edge using the inputs present at the edge.
  task automatic model_update();
    bit pop;
    bit en;
    int g;
    int j;
    if (!rst) begin
      model_reset();
      return;
    end
    pop = (exp_q.size() != 0) && cdb_ready;
    en  = (exp_q.size() < QD) || pop;
    g   = -1;
    if (en) begin
      for (int k = 0; k < NF; k++) begin
`ifdef BCAST_FIXED_PRIO_EN
        j = k;
`else
        j = (m_rr + k) % NF;
`endif
        if (g < 0 && m_pend[j]) g = j;
      end
    end
    if (pop) void'(exp_q.pop_front());
    exp_queued = '0;
    if (g >= 0) begin
      exp_q.push_back({m_tag[g], m_data[g]});
      m_pend[g]     = 1'b0;
      m_rr          = (g + 1) % NF;
      exp_queued[g] = 1'b1;
    end
    for (int i = 0; i < NF; i++) begin
      if (fu_done[i]) begin
        if (m_pend[i]) m_ovr = 1'b1;
        m_data[i] = fu_result[i*DW +: DW];
        m_tag[i]  = fu_tag[i*TW +: TW];
        m_pend[i] = 1'b1;
      end
    end
  endtask

  // ------------------------------------------------------------------ drivers
  task automatic set_done(input int i, input logic [DW-1:0] d, input logic [TW-1:0] t);
    fu_done[i]          = 1'b1;
    fu_result[i*DW +: DW] = d;
    fu_tag[i*TW +: TW]    = t;
  endtask

  // One clock: model follows the edge, outputs settle, done pulses drop.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    fu_done = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cdb_ready = 1'b0;
    fu_done = '0;
    model_reset();
    step();
    step();
    rst = 1'b1;
  endtask

  // -------------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b0;
    fu_done = '0;
    fu_result = '0;
    fu_tag = '0;
    cdb_ready = 1'b1;
    model_reset();
    step();
    step();
    n_checks++; if (cdb_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b want 0", cdb_valid); end
    n_checks++; if (queue_count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", queue_count); end
    n_checks++; if (fu_queued !== 4'b0) begin n_errors++; $display("FAIL reset_queued: got %b want 0000", fu_queued); end
    n_checks++; if (cdb_data !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h want 0", cdb_data); end
    n_checks++; if (cdb_tag !== 7'h0) begin n_errors++; $display("FAIL reset_tag: got %h want 0", cdb_tag); end
    n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    cdb_ready = 1'b1;
    set_done(2, 32'hDEADBEEF, 7'd5);
    step();
    n_checks++; if (cdb_valid !== 1'b0 || fu_queued !== 4'b0) begin n_errors++; $display("FAIL single_t1: valid=%0b queued=%b want 0/0000", cdb_valid, fu_queued); end
    step();
    n_checks++; if (fu_queued !== 4'b0100) begin n_errors++; $display("FAIL single_queued: got %b want 0100", fu_queued); end
    n_checks++; if (cdb_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %0b want 1", cdb_valid); end
    n_checks++; if (cdb_data !== 32'hDEADBEEF || cdb_tag !== 7'd5) begin n_errors++; $display("FAIL single_payload: got %h/%0d want deadbeef/5", cdb_data, cdb_tag); end
    step();
    n_checks++; if (cdb_valid !== 1'b0 || fu_queued !== 4'b0) begin n_errors++; $display("FAIL single_oneshot: valid=%0b queued=%b want 0/0000", cdb_valid, fu_queued); end
  endtask

  task automatic test_all_four();
    do_reset();
    cdb_ready = 1'b1;
    for (int i = 0; i < NF; i++) set_done(i, 32'h1000 + i, TW'(i + 1));
    step();
    for (int k = 0; k < NF; k++) begin
      step();
      n_checks++; if (fu_queued !== 4'(1 << k)) begin n_errors++; $display("FAIL order_queued[%0d]: got %b want %b", k, fu_queued, 4'(1 << k)); end
      n_checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'h1000 + k) begin n_errors++; $display("FAIL order_data[%0d]: valid=%0b data=%h want 1/%h", k, cdb_valid, cdb_data, 32'h1000 + k); end
    end
    step();
    n_checks++; if (cdb_valid !== 1'b0 || fu_queued !== 4'b0) begin n_errors++; $display("FAIL order_drained: valid=%0b queued=%b", cdb_valid, fu_queued); end
  endtask

  task automatic test_tie();
    logic [NF-1:0] want1;
    logic [NF-1:0] want2;
    do_reset();
    cdb_ready = 1'b1;
    set_done(0, 32'hB000, 7'd1);
    step();
    step();
    set_done(0, 32'hB0B0, 7'd2);
    set_done(1, 32'hB1B1, 7'd3);
    step();
    step();
`ifdef BCAST_FIXED_PRIO_EN
    want1 = 4'b0001; want2 = 4'b0010;
`else
    want1 = 4'b0010; want2 = 4'b0001;
`endif
    n_checks++; if (fu_queued !== want1) begin n_errors++; $display("FAIL tie_first: got %b want %b", fu_queued, want1); end
    step();
    n_checks++; if (fu_queued !== want2) begin n_errors++; $display("FAIL tie_second: got %b want %b", fu_queued, want2); end
  endtask

  task automatic test_full();
    do_reset();
    cdb_ready = 1'b0;
    for (int i = 0; i < NF; i++) set_done(i, 32'hC000 + i, TW'(i));
    step();
    step();
    set_done(0, 32'h5555_5555, 7'd55);
    step();
    step();
    step();
    n_checks++; if (queue_count !== 3'd4) begin n_errors++; $display("FAIL full_count: got %0d want 4", queue_count); end
    step();
    n_checks++; if (queue_count !== 3'd4 || fu_queued !== 4'b0) begin n_errors++; $display("FAIL full_hold: count=%0d queued=%b want 4/0000", queue_count, fu_queued); end
    step();
    n_checks++; if (queue_count !== 3'd4 || fu_queued !== 4'b0) begin n_errors++; $display("FAIL full_hold2: count=%0d queued=%b want 4/0000", queue_count, fu_queued); end
    n_checks++; if (cdb_data !== 32'hC000) begin n_errors++; $display("FAIL full_head: got %h want c000", cdb_data); end
    cdb_ready = 1'b1;
    step();
    cdb_ready = 1'b0;
    n_checks++; if (queue_count !== 3'd4) begin n_errors++; $display("FAIL full_pushpop_count: got %0d want 4", queue_count); end
    n_checks++; if (fu_queued !== 4'b0001) begin n_errors++; $display("FAIL full_fifth_queued: got %b want 0001", fu_queued); end
    n_checks++; if (cdb_data !== 32'hC001) begin n_errors++; $display("FAIL full_next_head: got %h want c001", cdb_data); end
  endtask

  task automatic test_fairness();
    int order [$];
    int c0;
    int c3;
    do_reset();
    cdb_ready = 1'b1;
    set_done(0, 32'hF0, 7'd0);
    set_done(3, 32'hF3, 7'd3);
    for (int c = 0; c < 100 && order.size() < 20; c++) begin
      step();
      if (fu_queued[0]) begin order.push_back(0); set_done(0, 32'hF0 + c, 7'd0); end
      if (fu_queued[3]) begin order.push_back(3); set_done(3, 32'hF3 + c, 7'd3); end
    end
    fu_done = '0;
    n_checks++; if (order.size() != 20) begin n_errors++; $display("FAIL fair_timeout: got %0d grants want 20", order.size()); end
    c0 = 0;
    c3 = 0;
    for (int k = 0; k < order.size(); k++) begin
      if (order[k] == 0) c0++;
      if (order[k] == 3) c3++;
      n_checks++; if (order[k] != ((k % 2 == 0) ? 0 : 3)) begin n_errors++; $display("FAIL fair_order[%0d]: got FU%0d want FU%0d", k, order[k], (k % 2 == 0) ? 0 : 3); end
    end
    n_checks++; if (c0 != 10 || c3 != 10) begin n_errors++; $display("FAIL fair_balance: FU0=%0d FU3=%0d want 10/10", c0, c3); end
    step();
    step();
  endtask

  task automatic test_overrun();
    logic [DW-1:0] got [$];
    logic [DW-1:0] want [5];
    do_reset();
    cdb_ready = 1'b0;
    for (int i = 0; i < NF; i++) set_done(i, 32'hA0 + i, TW'(i));
    step();
    repeat (4) step();
    set_done(1, 32'h1111_1111, 7'd1);
    step();
    n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_early: got %0b want 0", overrun); end
    set_done(1, 32'h2222_2222, 7'd2);
    step();
    n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_set: got %0b want 1", overrun); end
    want[0] = 32'hA0; want[1] = 32'hA1; want[2] = 32'hA2; want[3] = 32'hA3; want[4] = 32'h2222_2222;
    cdb_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      if (cdb_valid) got.push_back(cdb_data);
      step();
    end
    n_checks++; if (got.size() != 5) begin n_errors++; $display("FAIL ovr_drain_timeout: got %0d entries want 5", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      n_checks++; if (got[k] !== want[k]) begin n_errors++; $display("FAIL ovr_seq[%0d]: got %h want %h", k, got[k], want[k]); end
    end
    n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_sticky: got %0b want 1", overrun); end
  endtask

  task automatic test_coincident();
    logic [DW-1:0] got [$];
    do_reset();
    cdb_ready = 1'b1;
    set_done(1, 32'h0C0C_0C0C, 7'd3);
    step();
    set_done(1, 32'h0D0D_0D0D, 7'd4);
    step();
    for (int c = 0; c < 10 && got.size() < 2; c++) begin
      if (cdb_valid) got.push_back(cdb_data);
      step();
    end
    n_checks++; if (got.size() != 2) begin n_errors++; $display("FAIL coin_timeout: got %0d entries want 2", got.size()); end
    else begin
      n_checks++; if (got[0] !== 32'h0C0C_0C0C || got[1] !== 32'h0D0D_0D0D) begin n_errors++; $display("FAIL coin_seq: got %h,%h want 0c0c0c0c,0d0d0d0d", got[0], got[1]); end
    end
    n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL coin_overrun: got %0b want 0", overrun); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cdb_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_done(i, 32'hE0 + i, TW'(i));
    step();
    repeat (3) step();
    n_checks++; if (queue_count !== 3'd3 || fu_queued !== 4'b0100) begin n_errors++; $display("FAIL arst_pre: count=%0d queued=%b want 3/0100", queue_count, fu_queued); end
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    n_checks++; if (cdb_valid !== 1'b0) begin n_errors++; $display("FAIL arst_valid: got %0b want 0", cdb_valid); end
    n_checks++; if (queue_count !== 3'd0) begin n_errors++; $display("FAIL arst_count: got %0d want 0", queue_count); end
    n_checks++; if (fu_queued !== 4'b0) begin n_errors++; $display("FAIL arst_queued: got %b want 0000", fu_queued); end
    n_checks++; if (cdb_data !== 32'h0) begin n_errors++; $display("FAIL arst_data: got %h want 0", cdb_data); end
    #2;
    rst = 1'b1;
    cdb_ready = 1'b1;
    set_done(1, 32'h1234_5678, 7'd9);
    step();
    n_checks++; if (cdb_valid !== 1'b0 || fu_queued !== 4'b0) begin n_errors++; $display("FAIL arst_no_stale: valid=%0b queued=%b want 0/0000", cdb_valid, fu_queued); end
    step();
    n_checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'h1234_5678 || cdb_tag !== 7'd9) begin n_errors++; $display("FAIL arst_new: valid=%0b data=%h tag=%0d want 1/12345678/9", cdb_valid, cdb_data, cdb_tag); end
    n_checks++; if (fu_queued !== 4'b0010 || queue_count !== 3'd1) begin n_errors++; $display("FAIL arst_new_q: queued=%b count=%0d want 0010/1", fu_queued, queue_count); end
    step();
    n_checks++; if (cdb_valid !== 1'b0) begin n_errors++; $display("FAIL arst_drained: got %0b want 0", cdb_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NF; i++) begin
        if ($urandom_range(0, 3) == 0) set_done(i, $urandom, TW'($urandom_range(0, 127)));
      end
      cdb_ready = ($urandom_range(0, 2) != 0);
      step();
      n_checks++; if (fu_queued !== exp_queued) begin n_errors++; $display("FAIL rnd_queued@%0d: got %b want %b", c, fu_queued, exp_queued); end
      n_checks++; if (queue_count !== 3'(exp_q.size())) begin n_errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, queue_count, exp_q.size()); end
      n_checks++; if (cdb_valid !== (exp_q.size() != 0)) begin n_errors++; $display("FAIL rnd_valid@%0d: got %0b want %0b", c, cdb_valid, exp_q.size() != 0); end
      n_checks++; if (overrun !== m_ovr) begin n_errors++; $display("FAIL rnd_overrun@%0d: got %0b want %0b", c, overrun, m_ovr); end
      if (exp_q.size() != 0) begin
        n_checks++; if ({cdb_tag, cdb_data} !== exp_q[0]) begin n_errors++; $display("FAIL rnd_head@%0d: got %h/%h want %h", c, cdb_tag, cdb_data, exp_q[0]); end
      end
    end
    cdb_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_tie();
    test_full();
    test_fairness();
    test_overrun();
    test_coincident();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
